// File: rtl/sync_reg_source_queue_pkg.sv
// Shared definitions for the synchronizer source-side staging queue.
package sync_reg_source_queue_pkg;

  localparam int COALESCE_OFF = 0;
  localparam int COALESCE_ON  = 1;

  // COUNT must represent 0..depth inclusive, hence one bit beyond the pointer width.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_reg_source_queue_if.sv
// Handshake bundle between local logic, the staging queue and the synchronizer.
interface sync_reg_source_queue_if #(
  parameter int width = 1,
  parameter int depth = 4
);
  import sync_reg_source_queue_pkg::*;

  localparam int CW = count_w(depth);

  logic             ENQ;
  logic [width-1:0] D_IN;
  logic             FULL_N;
  logic [CW-1:0]    COUNT;
  logic             sRDY;
  logic             sEN;
  logic [width-1:0] sD_OUT;
  logic             OVR;
  logic             ERR;

  modport slave (
    input  ENQ, D_IN, sRDY,
    output FULL_N, COUNT, sEN, sD_OUT, OVR, ERR
  );

  modport master (
    output ENQ, D_IN, sRDY,
    input  FULL_N, COUNT, sEN, sD_OUT, OVR, ERR
  );

endinterface

// File: rtl/sync_reg_source_queue_mem.sv
// Unreset register-array storage for the staging queue: one write port, async read.
module sync_reg_queue_mem #(
  parameter int width = 1,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [width-1:0]         wr_data,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [width-1:0]         rd_data
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_reg_source_queue.sv
// Circular FIFO staging register updates ahead of the handshake-pulse synchronizer,
// with an optional "latest value wins" overwrite policy when full.
module sync_reg_source_queue
  import sync_reg_source_queue_pkg::*;
#(
  parameter int width    = 1,
  parameter int depth    = 4,
  parameter int coalesce = COALESCE_OFF
) (
  input  logic                           CLK,
  input  logic                           RST,
  sync_reg_source_queue_if.slave         q
);

  localparam int PW = $clog2(depth);
  localparam int CW = count_w(depth);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_n_q, full_n_d;
  logic          ovr_q, ovr_d;
  logic          err_q, err_d;

  logic          pop, push, overwrite, reject, full;
  logic          wr_en;
  logic [PW-1:0] wr_addr;

  always_comb begin
    pop       = q.sRDY && (count_q != '0);
    full      = (count_q == CW'(depth));
    push      = 1'b0;
    overwrite = 1'b0;
    reject    = 1'b0;
    if (q.ENQ) begin
      if (!full) begin
        push = 1'b1;
      end else if (coalesce == COALESCE_ON) begin
        // A same-cycle pop frees a slot, so a full coalescing queue can still append.
        if (pop) push = 1'b1;
        else     overwrite = 1'b1;
      end else begin
        reject = 1'b1;
      end
    end

    head_d   = pop  ? head_q + PW'(1) : head_q;
    tail_d   = push ? tail_q + PW'(1) : tail_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_n_d = (count_d != CW'(depth));
    ovr_d    = overwrite;
    err_d    = err_q | reject;
    wr_en    = push | overwrite;
    wr_addr  = push ? tail_q : tail_q - PW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_n_q <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      full_n_q <= full_n_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
    end
  end

  sync_reg_queue_mem #(
    .width (width),
    .depth (depth)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (q.D_IN),
    .rd_addr (head_q),
    .rd_data (q.sD_OUT)
  );

  assign q.sEN    = pop;
  assign q.COUNT  = count_q;
  assign q.FULL_N = full_n_q;
  assign q.OVR    = ovr_q;
  assign q.ERR    = err_q;

endmodule

// File: tb/tb_sync_reg_source_queue.sv
// Drives a reject-mode and a coalescing-mode queue with identical traffic and
// compares both against queue-based reference models.
module tb_sync_reg_source_queue;
  import sync_reg_source_queue_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  sync_reg_source_queue_if #(.width(WIDTH), .depth(DEPTH)) if0 ();
  sync_reg_source_queue_if #(.width(WIDTH), .depth(DEPTH)) if1 ();

  sync_reg_source_queue #(.width(WIDTH), .depth(DEPTH), .coalesce(COALESCE_OFF)) dut0 (
    .CLK (clk),
    .RST (rst),
    .q   (if0.slave)
  );

  sync_reg_source_queue #(.width(WIDTH), .depth(DEPTH), .coalesce(COALESCE_ON)) dut1 (
    .CLK (clk),
    .RST (rst),
    .q   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun  = 0;
  int testsFail = 0;

  logic [WIDTH-1:0] m0[$];
  logic [WIDTH-1:0] m1[$];
  bit err0Exp, ovr1Exp, fullN0Exp, fullN1Exp;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("q0.COUNT",  32'(if0.COUNT),  32'(m0.size()));
    checkOutput("q0.FULL_N", 32'(if0.FULL_N), 32'(fullN0Exp));
    checkOutput("q0.sEN",    32'(if0.sEN),    32'(if0.sRDY && m0.size() > 0));
    checkOutput("q0.OVR",    32'(if0.OVR),    32'(0));
    checkOutput("q0.ERR",    32'(if0.ERR),    32'(err0Exp));
    if (m0.size() > 0) checkOutput("q0.sD_OUT", 32'(if0.sD_OUT), 32'(m0[0]));
    checkOutput("q1.COUNT",  32'(if1.COUNT),  32'(m1.size()));
    checkOutput("q1.FULL_N", 32'(if1.FULL_N), 32'(fullN1Exp));
    checkOutput("q1.sEN",    32'(if1.sEN),    32'(if1.sRDY && m1.size() > 0));
    checkOutput("q1.OVR",    32'(if1.OVR),    32'(ovr1Exp));
    checkOutput("q1.ERR",    32'(if1.ERR),    32'(0));
    if (m1.size() > 0) checkOutput("q1.sD_OUT", 32'(if1.sD_OUT), 32'(m1[0]));
  endtask

  task automatic updateModel(input bit e, input logic [WIDTH-1:0] d, input bit r);
    bit p0, p1, full0;
    p0    = r && (m0.size() > 0);
    full0 = (m0.size() == DEPTH);
    if (e && full0) err0Exp = 1'b1;
    if (p0) void'(m0.pop_front());
    if (e && !full0) m0.push_back(d);

    p1      = r && (m1.size() > 0);
    ovr1Exp = 1'b0;
    if (p1) void'(m1.pop_front());
    if (e) begin
      if (m1.size() < DEPTH) m1.push_back(d);
      else begin
        m1[m1.size()-1] = d;
        ovr1Exp = 1'b1;
      end
    end
    fullN0Exp = (m0.size() != DEPTH);
    fullN1Exp = (m1.size() != DEPTH);
  endtask

  task automatic clearModel();
    m0.delete();
    m1.delete();
    err0Exp   = 1'b0;
    ovr1Exp   = 1'b0;
    fullN0Exp = 1'b0;
    fullN1Exp = 1'b0;
  endtask

  task automatic applyStimulus(input bit e, input logic [WIDTH-1:0] d, input bit r);
    if0.ENQ = e;  if0.D_IN = d;  if0.sRDY = r;
    if1.ENQ = e;  if1.D_IN = d;  if1.sRDY = r;
    @(negedge clk);
    compareAll();
    @(posedge clk);
    updateModel(e, d, r);
    #1;
  endtask

  // Asserts reset between edges so the asynchronous clear is observed immediately.
  task automatic asyncReset();
    if0.sRDY = 1'b1;
    if1.sRDY = 1'b1;
    #2 rst = 1'b1;
    #1;
    clearModel();
    compareAll();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fill(input logic [WIDTH-1:0] a, b, c, dd);
    applyStimulus(1'b1, a,  1'b0);
    applyStimulus(1'b1, b,  1'b0);
    applyStimulus(1'b1, c,  1'b0);
    applyStimulus(1'b1, dd, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    if0.ENQ = 1'b0; if0.D_IN = '0; if0.sRDY = 1'b0;
    if1.ENQ = 1'b0; if1.D_IN = '0; if1.sRDY = 1'b0;
    clearModel();
    @(posedge clk);
    #1;
    compareAll();
    @(posedge clk);
    #1 rst = 1'b0;

    fill(8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain(5);

    fill(8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(1'b1, 8'h55, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain(5);

    fill(8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain(5);

    fill(8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(1'b1, 8'h66, 1'b1);
    drain(5);

    fill(8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(1'b0, 8'h00, 1'b1);
    asyncReset();
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 99) < 60),
                      8'($urandom),
                      1'($urandom_range(0, 99) < 45));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
